alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the 8-bit combinational ALU.
- Same four-operation adder datapath, with generic `WIDTH` and a valid/ready handshake on both sides.
- Two register stages and a status-flag output: zero, negative, carry, signed overflow.
- Optional carry-chain register so multi-word add/subtract runs as back-to-back operations.
- Sits between the operand sequencer and the result writeback in the datapath.

## Interface

Parameters
- `WIDTH`, 8: operand and result width in bits (≥2).

Ports
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept an operand beat.
- `in_a`  in  WIDTH: operand A.
- `in_b`  in  WIDTH: operand B.
- `in_op`  in  2: operation select, `{S1,S0}` encoding.
- `in_cin`  in  1: carry in.
- `in_chain`  in  1: take carry-in from the chain register instead of `in_cin` (needs `ALU_CARRY_CHAIN_EN`).
- `out_valid`  out  1: result beat valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_f`  out  WIDTH: result.
- `out_cout`  out  1: carry out.
- `out_z`  out  1: zero flag, `out_f == 0`.
- `out_n`  out  1: negative flag, `out_f[WIDTH-1]`.
- `out_v`  out  1: signed overflow flag.

## Operation

Operations. X is the first adder operand, Y the second; F = X + Y + cin, truncated to WIDTH.
- `00`: X=A, Y=B → A+B+cin.
- `01`: X=A, Y=0 → A+cin (pass/increment).
- `10`: X=~B, Y=0 → ~B+cin (invert/negate with cin=1).
- `11`: X=A, Y=~B → A+~B+cin (subtract with cin=1).

Width and flag rules
- The adder is WIDTH+1 bits wide; `out_cout` is bit WIDTH.
- `out_v = (X[MSB]==Y[MSB]) && (F[MSB]!=X[MSB])`.
- `out_z` and `out_n` are derived from the registered F.

Pipeline stages
- S1 registers `in_a`, `in_b`, `in_op` and the effective cin.
- S2 computes the result and registers F and all flags.
- Each stage has a valid bit.
- S2 loads when `!s2_valid || out_ready`.
- S1 loads when `!s1_valid || s2_load`.
- `in_ready = !s1_valid || s2_load`. This is combinational from `out_ready`; there is no combinational path from `in_valid` to `in_ready`.
- A beat transfers on `valid && ready`. Order is strictly preserved; no beat is dropped or duplicated.
- Outputs hold stable while `out_valid && !out_ready`.

Carry chain (macro on)
- The chain register `cq` is loaded with the adder carry out whenever S2 loads a valid beat.
- A beat with `in_chain=1` resolves its cin at S2 from `cq` when the preceding beat lands in S2 on the same edge, so back-to-back chained beats see the correct carry.
- `in_cin` is ignored for beats with `in_chain=1`.

## Timing

- Latency: 2 cycles from input acceptance to `out_valid`, when there is no backpressure.
- Throughput: one beat per cycle.
- Capacity: two beats in flight. With `out_ready` held low, `in_ready` drops after two beats have been accepted.
- Reset (synchronous): `s1_valid`, `s2_valid`, `cq`, `out_f`, and all flags reset to 0; `in_ready` is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats; no `out_valid` is produced for them.
- Simultaneous accept and emit (S2 full, `out_ready=1`, `in_valid=1`) is a full-throughput cycle with no bubble.
- Input signals are don't-care while `in_valid=0`; the pipeline registers may still load, but their valid bits stay 0.

## Configuration

- `ALU_CARRY_CHAIN_EN` defined:
  - The `cq` register and `in_chain` path are built.
  - Multi-word arithmetic uses chained beats.
- `ALU_CARRY_CHAIN_EN` undefined:
  - There is no `cq` register.
  - `in_chain` is ignored and the port is kept for interface stability.
  - `in_cin` is always used.

## Test plan

- Add wrap: WIDTH=8, op 00, A=0xFF, B=0x01, cin=0 → F=0x00, C=1, Z=1, N=0, V=0, two cycles after acceptance.
- Subtract: op 11, A=0x05, B=0x03, cin=1 → F=0x02, C=1. Op 10, B=0x0F, cin=0 → F=0xF0, N=1.
- Overflow: op 01, A=0x7F, cin=1 → F=0x80, V=1, N=1, C=0.
- Chain (macro on): back-to-back 16-bit add 0x01FF+0x0001.
  - Low beat: A=0xFF, B=0x01, cin=0 → F=0x00, C=1.
  - High beat: A=0x01, B=0x00, chain=1 → F=0x02.
  - Repeat with one idle cycle between the two beats; results are identical.
- Backpressure: `out_ready` low for 5 cycles while 4 beats are offered.
  - Exactly 2 beats are accepted, then `in_ready=0`.
  - `out_f` is held stable.
  - After release, all 4 results emerge in order with no bubbles.
- Reset with 2 beats in flight → `out_valid` stays 0 afterwards; `cq`=0, so the next chained beat uses carry 0.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined adder ALU with valid/ready handshake and Z/N/C/V flags.
// Optional carry-chain register (cq) for multi-word arithmetic, built when ALU_CARRY_CHAIN_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_cout,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v
);

    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_op;
    logic             s1_cin;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] f_next;
    logic             v_next;

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: operand registers carry no reset; their contents only matter when s1_valid is set.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_op  <= in_op;
            s1_cin <= in_cin;
        end
    end

`ifdef ALU_CARRY_CHAIN_EN
    logic s1_chain;
    logic cq;

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_chain <= in_chain;
        end
    end

    // Chained carry resolves at S2, so it sees the carry of the beat that just left S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cq <= 1'b0;
        end else if (s2_load && s1_valid) begin
            cq <= sum[WIDTH];
        end
    end

    assign cin_eff = s1_chain ? cq : s1_cin;
`else
    logic chain_unused;

    assign chain_unused = in_chain;
    assign cin_eff      = s1_cin;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x = '0;
        y = '0;
        case (s1_op)
            2'b00: begin x = s1_a;  y = s1_b;  end
            2'b01: begin x = s1_a;  y = '0;    end
            2'b10: begin x = ~s1_b; y = '0;    end
            default: begin x = s1_a; y = ~s1_b; end
        endcase
        sum    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin_eff};
        f_next = sum[WIDTH-1:0];
        v_next = (x[MSB] == y[MSB]) && (f_next[MSB] != x[MSB]);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_f    <= '0;
            out_cout <= 1'b0;
            out_z    <= 1'b0;
            out_n    <= 1'b0;
            out_v    <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_f    <= f_next;
                out_cout <= sum[WIDTH];
                out_z    <= (f_next == '0);
                out_n    <= f_next[MSB];
                out_v    <= v_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed test-plan cases plus randomized traffic
// scored against an arithmetic reference model. Chain expectations follow ALU_CARRY_CHAIN_EN.
module tb_alu_pipe;

`ifdef ALU_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       in_cin;
    logic       in_chain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_f;
    logic       out_cout;
    logic       out_z;
    logic       out_n;
    logic       out_v;

    logic [11:0] obs;
    assign obs = {out_cout, out_v, out_n, out_z, out_f};

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];
    logic        last_carry;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cout(out_cout), .out_z(out_z), .out_n(out_n), .out_v(out_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: pick operands per op, add as integers, flags from signed/unsigned ranges.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op, input logic cin);
        int x, y, s, sx, sy, ss;
        logic c, v, n, z;
        logic [7:0] f;
        case (op)
            2'd0: begin x = a;       y = b;       end
            2'd1: begin x = a;       y = 0;       end
            2'd2: begin x = 255 - b; y = 0;       end
            default: begin x = a;    y = 255 - b; end
        endcase
        s  = x + y + int'(cin);
        f  = 8'(s % 256);
        c  = (s >= 256);
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        ss = sx + sy + int'(cin);
        v  = (ss > 127) || (ss < -128);
        n  = (f >= 8'd128);
        z  = (f == 8'd0);
        return {c, v, n, z, f};
    endfunction

    // Scoreboard: transfers are predicted from signals stable across the negative edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_carry = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_without_beat", out_valid, 0);
                else check("model", obs, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                logic [11:0] e;
                e = model(in_a, in_b, in_op, (CHAIN && in_chain) ? last_carry : in_cin);
                exp_q.push_back(e);
                last_carry = e[11];
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic cin, input logic chain);
        bit ok = 0;
        in_a = a; in_b = b; in_op = op; in_cin = cin; in_chain = chain;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) check("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic cin, input logic chain,
                          input logic [11:0] exp);
        drive(a, b, op, cin, chain);
        check({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check(tag, obs, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] hi_exp;
        logic [7:0]  held_f;
        bit          have_f, acc, ended;
        int          idx, run;
        logic [7:0]  bp_a[4];
        logic [7:0]  bp_b[4];

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_cin = 1'b0; in_chain = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_flags_f", obs, 12'h000);

        single("add_wrap", 8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 12'h900);
        single("sub",      8'h05, 8'h03, 2'b11, 1'b1, 1'b0, 12'h802);
        single("invert",   8'h00, 8'h0F, 2'b10, 1'b0, 1'b0, 12'h2F0);
        single("ovf",      8'h7F, 8'h00, 2'b01, 1'b1, 1'b0, 12'h680);

        hi_exp = CHAIN ? 12'h002 : 12'h001;
        drive(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0);
        drive(8'h01, 8'h00, 2'b00, 1'b0, 1'b1);
        check("chain_b2b_lo", obs, 12'h900);
        @(posedge clk); #1;
        check("chain_b2b_hi", obs, hi_exp);

        drive(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("chain_gap_lo", obs, 12'h900);
        drive(8'h01, 8'h00, 2'b00, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("chain_gap_hi", obs, hi_exp);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: five stalled cycles with four beats on offer.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 8'($urandom);
            bp_b[i] = 8'($urandom);
        end
        out_ready = 1'b0; idx = 0; have_f = 0; held_f = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_a = bp_a[idx]; in_b = bp_b[idx]; in_op = 2'b00; in_cin = 1'b0;
            in_chain = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (out_valid) begin
                if (have_f) check("bp_hold_f", out_f, held_f);
                else begin held_f = out_f; have_f = 1; end
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1; run = 0; ended = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (idx < 4) begin
                in_a = bp_a[idx]; in_b = bp_b[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && !ended) run++;
            else if (run > 0) ended = 1;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_all_accepted", idx, 4);
        check("bp_no_bubble_run", run, 4);

        // Reset with two beats in flight; the first one leaves carry 1 behind.
        out_ready = 1'b0;
        drive(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0);
        drive(8'h01, 8'h01, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        check("rst_mid_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid_flush", out_valid, 0);
        end
        single("rst_chain", 8'h01, 8'h00, 2'b00, 1'b0, 1'b1, 12'h001);

        // Randomized traffic with random backpressure and chaining.
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 2'($urandom_range(0, 3));
            in_cin    = 1'($urandom_range(0, 1));
            in_chain  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
